// File: rtl/uart_tx_arbiter.sv
// Two-port round-robin arbiter feeding a single UART transmitter through one-byte holding registers.
// Optional WAIT_BUSY abort timer is enabled with `define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic       clk,
  input  logic       sys_rst_n,
  input  logic       p0_valid,
  input  logic [7:0] p0_data,
  output logic       p0_ready,
  input  logic       p1_valid,
  input  logic [7:0] p1_data,
  output logic       p1_ready,
  input  logic       tx_busy,
  output logic       send_en,
  output logic [7:0] send_data,
  output logic       grant_id,
  output logic       arb_busy,
  output logic       timeout_err
);

  localparam int unsigned DATA_W = 8;

  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 255) begin : g_tmo_range
    $error("uart_tx_arbiter: TIMEOUT_CYC must be within 2..255");
  end

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   hold0, hold1, hold0_nxt, hold1_nxt;
  logic                full0, full1, full0_nxt, full1_nxt;
  logic [DATA_W-1:0]   send_data_nxt;
  logic                grant_id_nxt;
  logic                grant_vld;
  logic                grant_sel;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned TMO_W = 8;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  logic [TMO_W-1:0] tmo_cnt, tmo_cnt_nxt;
  logic             tmo_fire;

  // Abort fires on the TIMEOUT_CYC-th idle-busy cycle spent in WAIT_BUSY
  always_comb begin
    tmo_fire    = 1'b0;
    tmo_cnt_nxt = '0;
    if (state == WAIT_BUSY && !tx_busy) begin
      if (tmo_cnt == TMO_LAST) begin
        tmo_fire = 1'b1;
      end else begin
        tmo_cnt_nxt = tmo_cnt + TMO_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      tmo_cnt     <= tmo_cnt_nxt;
      timeout_err <= tmo_fire;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

  // Next-state, arbitration and grant-side register loads
  always_comb begin
    state_nxt     = state;
    grant_vld     = 1'b0;
    grant_sel     = grant_id;
    send_data_nxt = send_data;
    grant_id_nxt  = grant_id;
    case (state)
      IDLE: begin
        if ((full0 || full1) && !tx_busy) begin
          grant_vld = 1'b1;
          grant_sel = (full0 && full1) ? ~grant_id : full1;
          state_nxt = LAUNCH;
        end
      end
      LAUNCH:    state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_nxt = WAIT_DONE;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (tmo_fire) begin
          state_nxt = IDLE;
        end
`endif
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_nxt = IDLE;
        end
      end
      default:   state_nxt = IDLE;
    endcase
    if (grant_vld) begin
      send_data_nxt = grant_sel ? hold1 : hold0;
      grant_id_nxt  = grant_sel;
    end
  end

  // Holding registers: a grant empties the slot; ready low blocks capture in that same cycle
  always_comb begin
    full0_nxt = full0;
    hold0_nxt = hold0;
    full1_nxt = full1;
    hold1_nxt = hold1;
    if (grant_vld && !grant_sel) begin
      full0_nxt = 1'b0;
    end else if (p0_valid && p0_ready) begin
      full0_nxt = 1'b1;
      hold0_nxt = p0_data;
    end
    if (grant_vld && grant_sel) begin
      full1_nxt = 1'b0;
    end else if (p1_valid && p1_ready) begin
      full1_nxt = 1'b1;
      hold1_nxt = p1_data;
    end
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      hold0     <= '0;
      hold1     <= '0;
      full0     <= 1'b0;
      full1     <= 1'b0;
      p0_ready  <= 1'b1;
      p1_ready  <= 1'b1;
      send_en   <= 1'b0;
      send_data <= '0;
      grant_id  <= 1'b1;
      arb_busy  <= 1'b0;
    end else begin
      state     <= state_nxt;
      hold0     <= hold0_nxt;
      hold1     <= hold1_nxt;
      full0     <= full0_nxt;
      full1     <= full1_nxt;
      p0_ready  <= ~full0_nxt;
      p1_ready  <= ~full1_nxt;
      send_en   <= (state_nxt == LAUNCH);
      send_data <= send_data_nxt;
      grant_id  <= grant_id_nxt;
      arb_busy  <= (state_nxt != IDLE);
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYC, 16, max cycles in WAIT_BUSY before abort (used only with UART_ARB_TIMEOUT_EN); legal range 2..255.
REQ-002 Port: clk  input  1  system clock, all logic on rising edge.
REQ-003 Port: sys_rst_n  input  1  system reset, asynchronous, active-low.
REQ-004 Port: p0_valid  input  1  requester 0 has a byte.
REQ-005 Port: p0_data  input  8  requester 0 byte.
REQ-006 Port: p0_ready  output  1  requester 0 holding register empty.
REQ-007 Port: p1_valid  input  1  requester 1 has a byte.
REQ-008 Port: p1_data  input  8  requester 1 byte.
REQ-009 Port: p1_ready  output  1  requester 1 holding register empty.
REQ-010 Port: tx_busy  input  1  UART transmitter busy flag.
REQ-011 Port: send_en  output  1  one-cycle transmit start pulse to UART transmitter.
REQ-012 Port: send_data  output  8  byte to transmit.
REQ-013 Port: grant_id  output  1  index of the most recently granted requester.
REQ-014 Port: arb_busy  output  1  high whenever FSM is not IDLE.
REQ-015 Port: timeout_err  output  1  one-cycle pulse on transmit-start timeout.

Function
REQ-016 Each port SHALL have a one-byte holding register; pN_ready SHALL equal NOT hold_full_N, registered.
REQ-017 Byte SHALL be captured at the edge where pN_valid and pN_ready are both high; hold_full_N set from that edge.
REQ-018 FSM states SHALL be IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
REQ-019 IDLE -> LAUNCH SHALL occur when at least one hold register is full and tx_busy is low; otherwise remain IDLE.
REQ-020 Arbitration SHALL be round-robin: if both full, grant the port not equal to grant_id; if one full, grant it.
REQ-021 On grant, send_data SHALL load the granted byte, grant_id SHALL update, and the granted hold register SHALL clear at the same edge.
REQ-022 A port cleared by grant SHALL show ready high the following cycle and MAY accept a new byte then.
REQ-023 LAUNCH SHALL last exactly one cycle with send_en high; send_en SHALL be low in all other states.
REQ-024 WAIT_BUSY -> WAIT_DONE when tx_busy is high; WAIT_DONE -> IDLE when tx_busy is low.
REQ-025 send_data SHALL stay stable from grant until the next grant.
REQ-026 Latency: capture at edge k with FSM idle and tx_busy low SHALL give send_en high in the cycle after edge k+1.
REQ-027 No byte SHALL be dropped or duplicated; per-port order SHALL be preserved.
REQ-028 A port becoming full while FSM is not IDLE SHALL wait; it is arbitrated on the next IDLE cycle.

Reset
REQ-029 On sys_rst_n low: FSM=IDLE, hold registers empty, send_en=0, send_data=8'h00, grant_id=1, arb_busy=0, timeout_err=0, timeout counter=0.
REQ-030 pN_ready SHALL be 1 after reset; reset mid-transfer SHALL discard held and in-flight bytes with no send_en pulse.
REQ-031 With grant_id=1 after reset, port 0 SHALL win the first simultaneous request.

Configuration
REQ-032 Macro UART_ARB_TIMEOUT_EN defined: a counter SHALL run in WAIT_BUSY; after TIMEOUT_CYC cycles with tx_busy low, FSM SHALL go to IDLE and timeout_err SHALL pulse one cycle; the byte is lost.
REQ-033 Macro UART_ARB_TIMEOUT_EN undefined: WAIT_BUSY SHALL wait indefinitely, no counter SHALL be synthesised, and timeout_err SHALL be tied to 0.

Verification
REQ-034 Single send: p0 sends 8'hA5, model tx_busy high 3..12 cycles after send_en -> one send_en pulse, send_data=8'hA5, grant_id=0, p0_ready high again.
REQ-035 Contention: p0=8'h11 and p1=8'h22 captured the same cycle after reset -> order 11, 22; then both again -> 11, 22 (alternating).
REQ-036 Back-pressure: p1 streams 8'h01..8'h04 continuously -> four send_en pulses, data 01..04 in order, none dropped.
REQ-037 tx_busy already high in IDLE with p0 full -> no send_en until tx_busy falls, then send_en within 2 cycles.
REQ-038 Reset asserted during WAIT_DONE with p1 full -> all outputs at reset values, no send_en after release until new capture.
REQ-039 With UART_ARB_TIMEOUT_EN, TIMEOUT_CYC=16, tx_busy held low -> timeout_err pulse 16 cycles after WAIT_BUSY entry, FSM IDLE; without macro -> arb_busy stays high, timeout_err stays 0.
